// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone memory arbiter.
// State encoding plus small index-arithmetic helpers used by the top and the round-robin picker.
package wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;

    // Index width that stays legal for a single master.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping mod N.
// Produces one-hot grant, binary index and a valid flag.
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // NOTE: every output gets a default before the search loop, so no path leaves one unassigned (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[wrap_add(int'(ptr), i, N)]) begin
                valid                               = 1'b1;
                gnt[wrap_add(int'(ptr), i, N)]      = 1'b1;
                idx                                 = IW'(wrap_add(int'(ptr), i, N));
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master pipelined Wishbone arbiter in front of a single memory slave.
// Round-robin grant held for a whole bus cycle; a bounded counter tracks issued-but-unanswered requests.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int AW              = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      cpu_clock_i,
    input  logic                      cpu_reset_ni,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    output logic [NUM_MASTERS-1:0]    m_stall_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic                      s_stall_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic [31:0]               s_dat_i
);

    localparam int IDXW = idx_width(NUM_MASTERS);
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_OUTSTANDING);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    arb_state_t             state, state_next;
    logic [IDXW-1:0]        owner, rr_ptr;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [CNTW-1:0]        outstanding, outstanding_next;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IDXW-1:0]        arb_idx;
    logic                   arb_valid;
    logic                   full, owner_cyc, issue, retire, drained;

    rr_arbiter #(.N(NUM_MASTERS), .IW(IDXW)) u_rr (
        .req   (m_cyc_i),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign full      = (outstanding == CNT_MAX);
    assign owner_cyc = m_cyc_i[owner];

    assign s_we_o  = m_we_i[owner];
    assign s_adr_o = m_adr_i[owner*AW +: AW];
    assign s_dat_o = m_dat_i[owner*32 +: 32];
    assign s_sel_o = m_sel_i[owner*4 +: 4];
    assign m_dat_o = s_dat_i;

    // A response with nothing outstanding is spurious and must not underflow the count.
    assign issue   = s_stb_o & ~s_stall_i;
    assign retire  = (s_ack_i | s_err_i) & (outstanding != '0);
    assign drained = (outstanding == '0) | ((outstanding == CNT_ONE) & retire);

    always_comb begin
        outstanding_next = outstanding;
        if (issue && !retire)
            outstanding_next = outstanding + CNT_ONE;
        else if (retire && !issue)
            outstanding_next = outstanding - CNT_ONE;
    end

    always_comb begin
        state_next = state;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m_stall_o  = '1;
        m_ack_o    = '0;
        m_err_o    = '0;
        unique case (state)
            IDLE: begin
                if (arb_valid)
                    state_next = GRANT;
            end
            GRANT: begin
                s_cyc_o   = 1'b1;
                // Full stall uses the registered count, even when an ack lands this cycle.
                s_stb_o   = owner_cyc & m_stb_i[owner] & ~full;
                m_stall_o = ~owner_oh | {NUM_MASTERS{s_stall_i | full}};
                m_ack_o   = owner_oh & {NUM_MASTERS{s_ack_i}};
                m_err_o   = owner_oh & {NUM_MASTERS{s_err_i}};
                if (!owner_cyc)
                    state_next = (outstanding == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                s_cyc_o = 1'b1;
                if (drained)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_ni) begin
            state       <= IDLE;
            owner       <= '0;
            owner_oh    <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (state == IDLE && arb_valid) begin
                owner    <= arb_idx;
                owner_oh <= arb_gnt;
            end
            if (state == GRANT && !owner_cyc)
                rr_ptr <= IDXW'(wrap_add(int'(owner), 1, NUM_MASTERS));
        end
    end

endmodule
